// File: rtl/muldiv_unit_if.sv
// Start/busy/done handshake between pipeline control and the multiply/divide unit.
// Carries the operands, the MTHI/MTLO write port and the HI/LO read-out.
// Control drives the request side (master); the unit answers (slave).
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             whi;
  logic             wlo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, cancel, whi, wlo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel, whi, wlo, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU executor owning the HI/LO pair (optional macro MUL_EARLY_OUT_EN).
// Latency: WIDTH+2 edges from start to done; with MUL_EARLY_OUT_EN multiplies take msb(|b|)+3.
// No backpressure: start is accepted only in IDLE, ignored while busy; cancel abandons the op.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic          clock,
  input logic          reset,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  localparam int CW = $clog2(WIDTH) + 1;

  state_t             state, state_nxt;
  logic [2*WIDTH-1:0] acc;      // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   opnd;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   a_raw;    // original dividend, returned in HI on divide-by-zero
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [CW-1:0]      cnt;      // iterations completed
  logic               is_div, neg_q, neg_r, b_zero;
`ifdef MUL_EARLY_OUT_EN
  logic [WIDTH-1:0]   mrem;     // multiplier bits not yet consumed
`endif

  logic               launch, signed_op, calc_last;
  logic [WIDTH-1:0]   a_mag, b_mag;

  assign launch    = (state == IDLE) && bus.start && !bus.cancel;
  assign signed_op = !bus.op[0];
  assign a_mag     = (signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag     = (signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // One radix-2 step for each operation class.
  logic [WIDTH:0]     mul_sum, div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] mul_step, div_step;

  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, ({WIDTH{acc[0]}} & opnd)};
  assign mul_step = {mul_sum, acc[WIDTH-1:1]};
  assign div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_ge   = div_sh >= {1'b0, opnd};
  assign div_rem  = div_ge ? WIDTH'(div_sh - {1'b0, opnd}) : div_sh[WIDTH-1:0];
  assign div_step = {div_rem, acc[WIDTH-2:0], div_ge};

`ifdef MUL_EARLY_OUT_EN
  // Stop multiplying once no set multiplier bits remain beyond the one being consumed.
  assign calc_last = (cnt == CW'(WIDTH - 1)) || (!is_div && ((mrem >> 1) == '0));
`else
  assign calc_last = (cnt == CW'(WIDTH - 1));
`endif

  // Sign correction applied on the way out of FIX.
  logic [2*WIDTH-1:0] prod_mag, prod;
  logic [WIDTH-1:0]   quot, rem;

`ifdef MUL_EARLY_OUT_EN
  logic [CW-1:0] sh_amt;
  // An early exit leaves the product high by the number of skipped iterations.
  assign sh_amt   = CW'(WIDTH) - cnt;
  assign prod_mag = acc >> sh_amt;
`else
  assign prod_mag = acc;
`endif

  assign prod = neg_q ? -prod_mag : prod_mag;
  assign quot = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and status outputs; cancel drops any non-IDLE state back to IDLE.
  always_comb begin
    state_nxt = state;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    case (state)
      IDLE: if (launch) state_nxt = CALC;
      CALC: begin
        bus.busy = 1'b1;
        if (bus.cancel)     state_nxt = IDLE;
        else if (calc_last) state_nxt = FIX;
      end
      FIX: begin
        bus.busy  = 1'b1;
        state_nxt = bus.cancel ? IDLE : DONE;
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, result write-back and MTHI/MTLO.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      opnd   <= '0;
      a_raw  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
`ifdef MUL_EARLY_OUT_EN
      mrem   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.whi) hi_q <= bus.wdata;
          if (bus.wlo) lo_q <= bus.wdata;
          if (launch) begin
            is_div <= bus.op[1];
            neg_q  <= signed_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_r  <= signed_op && bus.a[WIDTH-1];
            b_zero <= (bus.b == '0);
            a_raw  <= bus.a;
            cnt    <= '0;
            if (bus.op[1]) begin
              acc  <= {{WIDTH{1'b0}}, a_mag};
              opnd <= b_mag;
            end else begin
              acc  <= {{WIDTH{1'b0}}, b_mag};
              opnd <= a_mag;
            end
`ifdef MUL_EARLY_OUT_EN
            mrem <= b_mag;
`endif
          end
        end
        CALC: begin
          if (!bus.cancel) begin
            acc <= is_div ? div_step : mul_step;
            cnt <= cnt + CW'(1);
`ifdef MUL_EARLY_OUT_EN
            mrem <= mrem >> 1;
`endif
          end
        end
        FIX: begin
          if (!bus.cancel) begin
            if (!is_div) begin
              {hi_q, lo_q} <= prod;
            end else if (b_zero) begin
              hi_q <= a_raw;
              lo_q <= '1;
            end else begin
              hi_q <= rem;
              lo_q <= quot;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.hi = hi_q;
  assign bus.lo = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboarded bench for muldiv_unit: stimulus pushes model results, a monitor pops on done.
// Reference model uses plain 64-bit / integer arithmetic, including the divide boundary rules.
// Honors MUL_EARLY_OUT_EN for the expected multiply latency.
module tb_muldiv_unit;
  localparam int W = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  muldiv_unit_if #(.WIDTH(W)) bus ();
  muldiv_unit #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus));

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           s;
    int           lat;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference: architectural results straight from signed/unsigned arithmetic.
  task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] hi, output logic [W-1:0] lo, output int lat);
    longint      sa, sb;
    logic [63:0] p;
    int          ia, ib, h;
    logic [W-1:0] bm;
    hi  = '0;
    lo  = '0;
    lat = W + 2;
    ia  = $signed(a);
    ib  = $signed(b);
    case (op)
      2'd0: begin
        sa = longint'(ia);
        sb = longint'(ib);
        p  = 64'(sa * sb);
        {hi, lo} = p;
      end
      2'd1: begin
        p = {32'b0, a} * {32'b0, b};
        {hi, lo} = p;
      end
      2'd2: begin
        if (b == 0) begin lo = '1; hi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = 32'h8000_0000; hi = 0; end
        else begin lo = 32'(ia / ib); hi = 32'(ia % ib); end
      end
      default: begin
        if (b == 0) begin lo = '1; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
    endcase
`ifdef MUL_EARLY_OUT_EN
    if (op[1] == 1'b0) begin
      bm = (op == 2'd0 && b[W-1]) ? -b : b;
      h  = 0;
      for (int i = 0; i < W; i++) if (bm[i]) h = i;
      lat = h + 3;
    end
`else
    bm = b;
    h  = 0;
`endif
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clock) begin
    if (!reset && bus.done) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 want no done (cycle %0d)", cyc);
      end else begin
        mon_e = expq.pop_front();
        check("result_hi", 64'(bus.hi), 64'(mon_e.hi));
        check("result_lo", 64'(bus.lo), 64'(mon_e.lo));
        check("latency", 64'(cyc - mon_e.s + 1), 64'(mon_e.lat));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((expq.size() != 0 || bus.busy || bus.done) && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got busy=%0b pending=%0d want idle", bus.busy, expq.size());
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit want);
    exp_t e;
    int   l;
    logic [W-1:0] h, lo;
    model(op, a, b, h, lo, l);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    e.hi = h; e.lo = lo; e.s = cyc + 1; e.lat = l;
    if (want) expq.push_back(e);
    @(posedge clock); #1;
    bus.start = 1'b0;
    check("busy_after_start", 64'(bus.busy), 64'd1);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      4:       return ~32'($urandom_range(0, 19));
      default: return 32'($urandom());
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0;
    bus.cancel = 0; bus.whi = 0; bus.wlo = 0; bus.wdata = 0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_hi", 64'(bus.hi), 64'd0);
    check("reset_lo", 64'(bus.lo), 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Directed results and boundaries.
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    wait_idle();
    issue(2'd0, 32'hFFFF_FFFD, 32'd7, 1);
    wait_idle();
    issue(2'd2, 32'hFFFF_FFF9, 32'd2, 1);
    wait_idle();
    issue(2'd3, 32'd100, 32'd0, 1);
    wait_idle();
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    wait_idle();
    issue(2'd2, 32'hFFFF_FFF6, 32'd0, 1);
    wait_idle();
    issue(2'd1, 32'd5, 32'd1, 1);
    wait_idle();

    // A second start while busy must not disturb the running operation.
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    repeat (3) @(posedge clock);
    #1;
    bus.start = 1; bus.op = 2'd1; bus.a = 32'd2; bus.b = 32'd3;
    @(posedge clock); #1;
    bus.start = 0;
    wait_idle();
    repeat (3) @(posedge clock);
    #1;
    check("no_queued_start", 64'(bus.busy), 64'd0);

    // MTHI/MTLO in IDLE, then a cancelled divide with a stray MTHI while busy.
    bus.whi = 1; bus.wdata = 32'h1234;
    @(posedge clock); #1;
    bus.whi = 0;
    check("mthi_idle", 64'(bus.hi), 64'h1234);
    bus.wlo = 1; bus.wdata = 32'h5678;
    @(posedge clock); #1;
    bus.wlo = 0;
    check("mtlo_idle", 64'(bus.lo), 64'h5678);
    issue(2'd3, 32'd10, 32'd3, 0);
    @(posedge clock); #1;
    bus.whi = 1; bus.wdata = 32'hDEAD;
    @(posedge clock); #1;
    bus.whi = 0;
    @(posedge clock); #1;
    bus.cancel = 1;
    @(posedge clock); #1;
    bus.cancel = 0;
    check("cancel_busy", 64'(bus.busy), 64'd0);
    check("cancel_hi", 64'(bus.hi), 64'h1234);
    check("cancel_lo", 64'(bus.lo), 64'h5678);
    repeat (40) @(posedge clock);
    #1;
    check("cancel_hi_later", 64'(bus.hi), 64'h1234);

    // Cancel with start in IDLE drops the start.
    bus.start = 1; bus.cancel = 1; bus.op = 2'd1; bus.a = 32'd9; bus.b = 32'd9;
    @(posedge clock); #1;
    bus.start = 0; bus.cancel = 0;
    check("cancel_start_idle", 64'(bus.busy), 64'd0);

    // MTHI in the same cycle as start: written now, overwritten on completion.
    bus.whi = 1; bus.wdata = 32'h0ABC;
    issue(2'd3, 32'd17, 32'd5, 1);
    bus.whi = 0;
    check("mthi_with_start", 64'(bus.hi), 64'h0ABC);
    wait_idle();

    // Asynchronous reset in the middle of a divide.
    issue(2'd3, 32'd1000, 32'd7, 0);
    repeat (4) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_hi", 64'(bus.hi), 64'd0);
    check("rst_mid_lo", 64'(bus.lo), 64'd0);
    check("rst_mid_busy", 64'(bus.busy), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    // Randomized operations.
    for (int i = 0; i < 60; i++) begin
      logic [1:0] rop;
      rop = 2'($urandom_range(0, 3));
      issue(rop, pick(), pick(), 1);
      wait_idle();
    end

    wait_idle();
    repeat (5) @(posedge clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
